// File: rtl/apu_pmu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apu_pmu_pkg                                            |
// | Description : Shared types and default widths for the APU power      |
// |               management blocks (Q-channel device adapters).         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package apu_pmu_pkg;

  // Device-side Q-channel handshake states
  typedef enum logic [1:0] {
    QDEV_RUN     = 2'd0,
    QDEV_REQUEST = 2'd1,
    QDEV_STOPPED = 2'd2,
    QDEV_DENIED  = 2'd3
  } qdev_state_e;

  localparam int unsigned OSTD_WIDTH_DEFAULT         = 6;
  localparam int unsigned DENY_TIMEOUT_WIDTH_DEFAULT = 8;

endpackage : apu_pmu_pkg
`default_nettype wire

// File: rtl/apu_axi_qchannel_device_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apu_axi_qchannel_device_if                             |
// | Description : AXI handshake signals seen by the Q-channel device     |
// |               adapter. Names are relative to the adapter: i_* flow   |
// |               into it, o_* are produced by it.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface apu_axi_qchannel_device_if;

  // AW request path: manager -> adapter -> fabric
  logic i_s_aw_valid;
  logic o_s_aw_ready;
  logic o_m_aw_valid;
  logic i_m_aw_ready;

  // AR request path: manager -> adapter -> fabric
  logic i_s_ar_valid;
  logic o_s_ar_ready;
  logic o_m_ar_valid;
  logic i_m_ar_ready;

  // Response snoops
  logic i_b_valid;
  logic i_b_ready;
  logic i_r_valid;
  logic i_r_ready;
  logic i_r_last;

  // Adapter side
  modport slave (
    input  i_s_aw_valid, i_m_aw_ready,
    input  i_s_ar_valid, i_m_ar_ready,
    input  i_b_valid, i_b_ready,
    input  i_r_valid, i_r_ready, i_r_last,
    output o_s_aw_ready, o_m_aw_valid,
    output o_s_ar_ready, o_m_ar_valid
  );

  // Environment side (manager, fabric and response snoop drivers)
  modport master (
    output i_s_aw_valid, i_m_aw_ready,
    output i_s_ar_valid, i_m_ar_ready,
    output i_b_valid, i_b_ready,
    output i_r_valid, i_r_ready, i_r_last,
    input  o_s_aw_ready, o_m_aw_valid,
    input  o_s_ar_ready, o_m_ar_valid
  );

endinterface : apu_axi_qchannel_device_if
`default_nettype wire

// File: rtl/apu_axi_ostd_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apu_axi_ostd_counter                                   |
// | Description : Saturating up/down outstanding-transaction counter     |
// |               with a sticky underflow flag.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module apu_axi_ostd_counter
  import apu_pmu_pkg::*;
#(
  parameter int unsigned WIDTH = OSTD_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_full,
  output logic             o_underflow
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic             r_underflow;
  logic             w_full;
  logic             w_zero;

  assign w_full = &r_cnt;
  assign w_zero = (r_cnt == '0);

  // Count issued requests up and retired responses down; simultaneous
  // inc/dec cancel. A decrement at zero is a protocol error and is latched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_underflow <= 1'b0;
    end else begin
      case ({i_inc, i_dec})
        2'b10: begin
          if (!w_full) begin
            r_cnt <= r_cnt + c_one;
          end
        end
        2'b01: begin
          if (w_zero) begin
            r_underflow <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign o_cnt       = r_cnt;
  assign o_full      = w_full;
  assign o_underflow = r_underflow;

endmodule : apu_axi_ostd_counter
`default_nettype wire

// File: rtl/apu_axi_qchannel_device.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apu_axi_qchannel_device                                |
// | Description : Q-channel device-side adapter for one AXI manager      |
// |               port. Tracks outstanding traffic, gates new AW/AR      |
// |               requests during quiescence and answers QREQn with      |
// |               QACCEPTn or QDENY.                                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module apu_axi_qchannel_device
  import apu_pmu_pkg::*;
#(
  parameter int unsigned OUTSTANDING_WIDTH  = OSTD_WIDTH_DEFAULT,
  parameter int unsigned DENY_TIMEOUT_WIDTH = DENY_TIMEOUT_WIDTH_DEFAULT
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DENY_TIMEOUT_WIDTH-1:0] i_deny_timeout,
  input  logic                          i_qreq_n,
  output logic                          o_qaccept_n,
  output logic                          o_qdeny,
  output logic                          o_qactive,
  output logic                          o_cnt_err,
  apu_axi_qchannel_device_if.slave      bus
);

  localparam logic [DENY_TIMEOUT_WIDTH-1:0] c_timer_one = DENY_TIMEOUT_WIDTH'(1);

  qdev_state_e                   r_state;
  logic [DENY_TIMEOUT_WIDTH-1:0] r_timer;
  logic                          r_qaccept_n;
  logic                          r_qdeny;
  logic                          r_aw_pend;
  logic                          r_ar_pend;

  logic [OUTSTANDING_WIDTH-1:0]  w_wr_cnt;
  logic [OUTSTANDING_WIDTH-1:0]  w_rd_cnt;
  logic                          w_wr_full;
  logic                          w_rd_full;
  logic                          w_wr_udf;
  logic                          w_rd_udf;
  logic                          w_traffic_ok;
  logic                          w_aw_pass;
  logic                          w_ar_pass;
  logic                          w_m_aw_valid;
  logic                          w_m_ar_valid;
  logic                          w_aw_hs;
  logic                          w_ar_hs;
  logic                          w_b_hs;
  logic                          w_r_last_hs;
  logic                          w_busy;

  // New requests are admitted only outside a quiescence window, and only
  // while the counter has room. A request already presented downstream
  // keeps its pass until it handshakes so VALID is never withdrawn.
  assign w_traffic_ok = (r_state == QDEV_RUN) || (r_state == QDEV_DENIED);
  assign w_aw_pass    = (w_traffic_ok && !w_wr_full) || r_aw_pend;
  assign w_ar_pass    = (w_traffic_ok && !w_rd_full) || r_ar_pend;

  assign w_m_aw_valid = bus.i_s_aw_valid & w_aw_pass;
  assign w_m_ar_valid = bus.i_s_ar_valid & w_ar_pass;

  assign bus.o_m_aw_valid = w_m_aw_valid;
  assign bus.o_s_aw_ready = bus.i_m_aw_ready & w_aw_pass;
  assign bus.o_m_ar_valid = w_m_ar_valid;
  assign bus.o_s_ar_ready = bus.i_m_ar_ready & w_ar_pass;

  assign w_aw_hs     = w_m_aw_valid & bus.i_m_aw_ready;
  assign w_ar_hs     = w_m_ar_valid & bus.i_m_ar_ready;
  assign w_b_hs      = bus.i_b_valid & bus.i_b_ready;
  assign w_r_last_hs = bus.i_r_valid & bus.i_r_ready & bus.i_r_last;

  apu_axi_ostd_counter #(
    .WIDTH (OUTSTANDING_WIDTH)
  ) u_wr_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_inc       (w_aw_hs),
    .i_dec       (w_b_hs),
    .o_cnt       (w_wr_cnt),
    .o_full      (w_wr_full),
    .o_underflow (w_wr_udf)
  );

  apu_axi_ostd_counter #(
    .WIDTH (OUTSTANDING_WIDTH)
  ) u_rd_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_inc       (w_ar_hs),
    .i_dec       (w_r_last_hs),
    .o_cnt       (w_rd_cnt),
    .o_full      (w_rd_full),
    .o_underflow (w_rd_udf)
  );

  // Remember a request that was forwarded but not yet accepted downstream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aw_pend <= 1'b0;
      r_ar_pend <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_pend <= 1'b0;
      end else if (w_m_aw_valid) begin
        r_aw_pend <= 1'b1;
      end
      if (w_ar_hs) begin
        r_ar_pend <= 1'b0;
      end else if (w_m_ar_valid) begin
        r_ar_pend <= 1'b1;
      end
    end
  end

  assign w_busy = (w_wr_cnt != '0) || (w_rd_cnt != '0) || r_aw_pend || r_ar_pend;

  // Q-channel handshake: drain on request, accept when idle, deny when the
  // drain window expires. Drained wins over expiry in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= QDEV_RUN;
      r_timer     <= '0;
      r_qaccept_n <= 1'b1;
      r_qdeny     <= 1'b0;
    end else begin
      case (r_state)
        QDEV_RUN: begin
          if (!i_qreq_n) begin
            r_state <= QDEV_REQUEST;
            r_timer <= i_deny_timeout;
          end
        end
        QDEV_REQUEST: begin
          if (!w_busy) begin
            r_state     <= QDEV_STOPPED;
            r_qaccept_n <= 1'b0;
          end else if (r_timer == '0) begin
            r_state <= QDEV_DENIED;
            r_qdeny <= 1'b1;
          end else begin
            r_timer <= r_timer - c_timer_one;
          end
        end
        QDEV_STOPPED: begin
          if (i_qreq_n) begin
            r_state     <= QDEV_RUN;
            r_qaccept_n <= 1'b1;
          end
        end
        QDEV_DENIED: begin
          if (i_qreq_n) begin
            r_state <= QDEV_RUN;
            r_qdeny <= 1'b0;
          end
        end
        default: begin
          r_state     <= QDEV_RUN;
          r_qaccept_n <= 1'b1;
          r_qdeny     <= 1'b0;
        end
      endcase
    end
  end

  assign o_qaccept_n = r_qaccept_n;
  assign o_qdeny     = r_qdeny;
  // A raw manager VALID must be visible even while stopped, so the
  // controller can restart the gated fabric clock.
  assign o_qactive   = w_busy | bus.i_s_aw_valid | bus.i_s_ar_valid;
  assign o_cnt_err   = w_wr_udf | w_rd_udf;

endmodule : apu_axi_qchannel_device
`default_nettype wire

// File: tb/tb_apu_axi_qchannel_device.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_apu_axi_qchannel_device                             |
// | Description : Directed self-checking bench for the Q-channel device  |
// |               adapter with a transaction-level reference model.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_apu_axi_qchannel_device;

  localparam int MAXO = 63;

  localparam int PH_RUN  = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_STOP = 2;
  localparam int PH_DENY = 3;

  logic       clk;
  logic       rst_n;
  logic       qreq_n;
  logic [7:0] deny_to;
  logic       qaccept_n;
  logic       qdeny;
  logic       qactive;
  logic       cnt_err;

  int n_checks = 0;
  int n_fail   = 0;

  apu_axi_qchannel_device_if bus_if ();

  apu_axi_qchannel_device #(
    .OUTSTANDING_WIDTH  (6),
    .DENY_TIMEOUT_WIDTH (8)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_deny_timeout (deny_to),
    .i_qreq_n       (qreq_n),
    .o_qaccept_n    (qaccept_n),
    .o_qdeny        (qdeny),
    .o_qactive      (qactive),
    .o_cnt_err      (cnt_err),
    .bus            (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outstanding counts as plain integers; the drain window is an absolute
  // edge number at which a still-busy device gives up.
  int m_wr, m_rd, m_phase, m_deadline, m_edge;
  bit m_awp, m_arp, m_err;

  function automatic void model_reset();
    m_wr = 0; m_rd = 0; m_phase = PH_RUN; m_deadline = 0; m_edge = 0;
    m_awp = 0; m_arp = 0; m_err = 0;
  endfunction

  function automatic bit traffic_open();
    return (m_phase == PH_RUN) || (m_phase == PH_DENY);
  endfunction

  function automatic bit aw_pass();
    return (traffic_open() && (m_wr < MAXO)) || m_awp;
  endfunction

  function automatic bit ar_pass();
    return (traffic_open() && (m_rd < MAXO)) || m_arp;
  endfunction

  function automatic bit m_busy();
    return (m_wr > 0) || (m_rd > 0) || m_awp || m_arp;
  endfunction

  function automatic void model_step();
    bit aw_v, ar_v, aw_hs, ar_hs, b_hs, r_hs, busy;
    busy  = m_busy();
    aw_v  = bus_if.i_s_aw_valid && aw_pass();
    ar_v  = bus_if.i_s_ar_valid && ar_pass();
    aw_hs = aw_v && bus_if.i_m_aw_ready;
    ar_hs = ar_v && bus_if.i_m_ar_ready;
    b_hs  = bus_if.i_b_valid && bus_if.i_b_ready;
    r_hs  = bus_if.i_r_valid && bus_if.i_r_ready && bus_if.i_r_last;
    if (aw_hs && !b_hs) m_wr++;
    else if (b_hs && !aw_hs) begin
      if (m_wr == 0) m_err = 1; else m_wr--;
    end
    if (ar_hs && !r_hs) m_rd++;
    else if (r_hs && !ar_hs) begin
      if (m_rd == 0) m_err = 1; else m_rd--;
    end
    if (aw_hs) m_awp = 0; else if (aw_v) m_awp = 1;
    if (ar_hs) m_arp = 0; else if (ar_v) m_arp = 1;
    case (m_phase)
      PH_RUN:  if (!qreq_n) begin m_phase = PH_REQ; m_deadline = m_edge + int'(deny_to) + 1; end
      PH_REQ:  if (!busy) m_phase = PH_STOP; else if (m_edge >= m_deadline) m_phase = PH_DENY;
      PH_STOP: if (qreq_n) m_phase = PH_RUN;
      default: if (qreq_n) m_phase = PH_RUN;
    endcase
    m_edge++;
  endfunction

  // Compare every output against the model once per cycle, mid-period.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) model_reset();
    chk("m_aw_valid", 32'(bus_if.o_m_aw_valid), 32'(bus_if.i_s_aw_valid && aw_pass()));
    chk("s_aw_ready", 32'(bus_if.o_s_aw_ready), 32'(bus_if.i_m_aw_ready && aw_pass()));
    chk("m_ar_valid", 32'(bus_if.o_m_ar_valid), 32'(bus_if.i_s_ar_valid && ar_pass()));
    chk("s_ar_ready", 32'(bus_if.o_s_ar_ready), 32'(bus_if.i_m_ar_ready && ar_pass()));
    chk("qactive", 32'(qactive), 32'(m_busy() || bus_if.i_s_aw_valid || bus_if.i_s_ar_valid));
    chk("qaccept_n", 32'(qaccept_n), 32'(m_phase != PH_STOP));
    chk("qdeny", 32'(qdeny), 32'(m_phase == PH_DENY));
    chk("cnt_err", 32'(cnt_err), 32'(m_err));
    chk("accept_deny_excl", 32'(!qaccept_n && qdeny), 32'd0);
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; qreq_n = 1'b1; deny_to = 8'd0;
    bus_if.i_s_aw_valid = 0; bus_if.i_m_aw_ready = 0;
    bus_if.i_s_ar_valid = 0; bus_if.i_m_ar_ready = 0;
    bus_if.i_b_valid = 0; bus_if.i_b_ready = 0;
    bus_if.i_r_valid = 0; bus_if.i_r_ready = 0; bus_if.i_r_last = 0;
    tick(); tick();
    chk("rst_qaccept_n", 32'(qaccept_n), 32'd1);
    chk("rst_qdeny", 32'(qdeny), 32'd0);
    chk("rst_cnt_err", 32'(cnt_err), 32'd0);
    chk("rst_qactive", 32'(qactive), 32'd0);
    rst_n = 1'b1;
    tick();

    // Idle accept: two edges after QREQn falls, released one edge after it rises
    deny_to = 8'd4; qreq_n = 1'b0;
    tick(); chk("idle_acc_e1", 32'(qaccept_n), 32'd1);
    tick(); chk("idle_acc_e2", 32'(qaccept_n), 32'd0);
    qreq_n = 1'b1;
    tick(); chk("idle_release", 32'(qaccept_n), 32'd1);

    // Three ARs outstanding, drained by R-last during REQUEST
    bus_if.i_m_ar_ready = 1; bus_if.i_s_ar_valid = 1;
    tick(); tick(); tick();
    bus_if.i_s_ar_valid = 0; deny_to = 8'd10; qreq_n = 1'b0;
    tick();
    bus_if.i_s_ar_valid = 1; #1;
    chk("req_ar_blocked_v", 32'(bus_if.o_m_ar_valid), 32'd0);
    chk("req_ar_blocked_r", 32'(bus_if.o_s_ar_ready), 32'd0);
    bus_if.i_s_ar_valid = 0;
    bus_if.i_r_valid = 1; bus_if.i_r_ready = 1; bus_if.i_r_last = 1;
    tick(); tick(); tick();
    bus_if.i_r_valid = 0;
    chk("rd_drain_not_yet", 32'(qaccept_n), 32'd1);
    tick(); chk("rd_drain_accept", 32'(qaccept_n), 32'd0);
    chk("stopped_qactive0", 32'(qactive), 32'd0);
    bus_if.i_s_ar_valid = 1; #1;
    chk("stopped_wake", 32'(qactive), 32'd1);
    chk("stopped_ar_rdy", 32'(bus_if.o_s_ar_ready), 32'd0);
    tick(); tick();
    chk("stopped_ar_rdy2", 32'(bus_if.o_s_ar_ready), 32'd0);
    qreq_n = 1'b1;
    tick();
    chk("run_again_acc", 32'(qaccept_n), 32'd1);
    chk("run_again_ar_rdy", 32'(bus_if.o_s_ar_ready), 32'd1);
    tick();
    bus_if.i_s_ar_valid = 0; bus_if.i_r_valid = 1;
    tick();
    bus_if.i_r_valid = 0; bus_if.i_r_last = 0;

    // One AW outstanding, no B: deny after the drain window
    bus_if.i_m_aw_ready = 1; bus_if.i_s_aw_valid = 1;
    tick();
    bus_if.i_s_aw_valid = 0; deny_to = 8'd4; qreq_n = 1'b0;
    tick(); repeat (4) tick();
    chk("deny_not_yet", 32'(qdeny), 32'd0);
    tick();
    chk("deny_set", 32'(qdeny), 32'd1);
    chk("deny_no_accept", 32'(qaccept_n), 32'd1);
    bus_if.i_s_aw_valid = 1; #1;
    chk("deny_aw_flows_v", 32'(bus_if.o_m_aw_valid), 32'd1);
    chk("deny_aw_flows_r", 32'(bus_if.o_s_aw_ready), 32'd1);
    tick();
    bus_if.i_s_aw_valid = 0; qreq_n = 1'b1;
    tick(); chk("deny_clear", 32'(qdeny), 32'd0);
    bus_if.i_b_valid = 1; bus_if.i_b_ready = 1;
    tick(); tick();
    bus_if.i_b_valid = 0;

    // AW stalled when QREQn falls: VALID held, accept only after B
    bus_if.i_m_aw_ready = 0; bus_if.i_s_aw_valid = 1;
    tick();
    deny_to = 8'd20; qreq_n = 1'b0;
    tick(); chk("stall_hold1", 32'(bus_if.o_m_aw_valid), 32'd1);
    tick(); chk("stall_hold2", 32'(bus_if.o_m_aw_valid), 32'd1);
    bus_if.i_m_aw_ready = 1; #1;
    chk("stall_ready", 32'(bus_if.o_s_aw_ready), 32'd1);
    tick();
    bus_if.i_s_aw_valid = 0;
    tick(); chk("stall_wait_b", 32'(qaccept_n), 32'd1);
    bus_if.i_b_valid = 1;
    tick();
    bus_if.i_b_valid = 0;
    chk("stall_b_edge", 32'(qaccept_n), 32'd1);
    tick(); chk("stall_accept", 32'(qaccept_n), 32'd0);
    qreq_n = 1'b1;
    tick(); chk("stall_release", 32'(qaccept_n), 32'd1);

    // B with nothing outstanding, then saturate the write counter
    bus_if.i_b_valid = 1;
    tick();
    bus_if.i_b_valid = 0;
    chk("udf_err", 32'(cnt_err), 32'd1);
    chk("udf_cnt_zero", 32'(qactive), 32'd0);
    bus_if.i_s_aw_valid = 1;
    repeat (63) tick();
    chk("sat_aw_rdy", 32'(bus_if.o_s_aw_ready), 32'd0);
    chk("sat_aw_vld", 32'(bus_if.o_m_aw_valid), 32'd0);
    tick(); chk("sat_aw_rdy2", 32'(bus_if.o_s_aw_ready), 32'd0);
    bus_if.i_b_valid = 1;
    tick();
    bus_if.i_b_valid = 0;
    chk("sat_after_b", 32'(bus_if.o_s_aw_ready), 32'd1);
    tick(); chk("sat_full_again", 32'(bus_if.o_s_aw_ready), 32'd0);
    bus_if.i_s_aw_valid = 0;
    chk("sat_busy", 32'(qactive), 32'd1);

    // Asynchronous reset with traffic outstanding
    rst_n = 1'b0; #1;
    chk("arst_qactive", 32'(qactive), 32'd0);
    chk("arst_err", 32'(cnt_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); chk("post_rst_idle", 32'(qactive), 32'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_apu_axi_qchannel_device
`default_nettype wire

// File: doc/apu_axi_qchannel_device.md
Name: apu_axi_qchannel_device

Overview:
- Q-channel device-side adapter, one instance per AXI manager port of the APU fabric.
- Produces the per-device QACCEPTn/QDENY/QACTIVE that feed the fabric clock low-power controller, and consumes that controller's QREQn.
- Snoops AW/AR/B/R handshakes to track outstanding transactions, and blocks new AW/AR requests while a quiescence request is pending or granted.
- Runs on the ungated bus clock, so it can wake the gated fabric.

Parameters:
- OUTSTANDING_WIDTH, 6, width of each outstanding-transaction counter (max 2^W-1 per direction).
- DENY_TIMEOUT_WIDTH, 8, width of the drain-timeout counter and of i_deny_timeout.

Ports:
- i_clk  in  1  ungated fast bus clock
- i_rst_n  in  1  asynchronous active-low reset
- i_deny_timeout  in  DENY_TIMEOUT_WIDTH  cycles to wait for drain before denying; 0 = deny immediately if busy
- i_qreq_n  in  1  QREQn from the clock low-power controller
- o_qaccept_n  out  1  QACCEPTn
- o_qdeny  out  1  QDENY
- o_qactive  out  1  QACTIVE
- i_s_aw_valid / o_s_aw_ready  in/out  1  AW handshake from the manager
- o_m_aw_valid / i_m_aw_ready  out/in  1  AW handshake towards the fabric
- i_s_ar_valid / o_s_ar_ready  in/out  1  AR handshake from the manager
- o_m_ar_valid / i_m_ar_ready  out/in  1  AR handshake towards the fabric
- i_b_valid, i_b_ready  in  1  B handshake snoop
- i_r_valid, i_r_ready, i_r_last  in  1  R handshake snoop
- o_cnt_err  out  1  sticky: response seen with a zero counter

Behaviour:
- Reset values: state RUN, o_qaccept_n=1, o_qdeny=0, all counters 0, o_cnt_err=0, pending flags 0.
- Counters:
  - wr_cnt +1 on the AW handshake (o_m_aw_valid & i_m_aw_ready); -1 on the B handshake.
  - rd_cnt +1 on the AR handshake; -1 on the R handshake with i_r_last.
  - Inc and dec in the same cycle: counter unchanged.
  - Dec at 0: counter holds 0 and o_cnt_err sets; it stays set until reset.
  - Counter at max: that channel is blocked until a decrement.
- Request gating:
  - allow = (state==RUN || state==DENIED) && counter != max.
  - o_m_aw_valid = i_s_aw_valid & (allow_aw | aw_pend); o_s_aw_ready = i_m_aw_ready & (allow_aw | aw_pend). AR is identical.
  - aw_pend is registered: set when o_m_aw_valid & !i_m_aw_ready; cleared on the handshake. A presented VALID is never withdrawn, so an in-flight request completes even after entering REQUEST.
- busy = wr_cnt!=0 | rd_cnt!=0 | aw_pend | ar_pend.
- o_qactive = busy_q | i_s_aw_valid | i_s_ar_valid. This is combinational on the valids so that a manager request wakes a STOPPED fabric.
- FSM (outputs registered, all transitions take effect on the next edge):
  - RUN: i_qreq_n=0 -> REQUEST; the timeout counter loads i_deny_timeout.
  - REQUEST: new AW/AR blocked.
    - !busy -> STOPPED (o_qaccept_n<=0).
    - Otherwise, timeout==0 -> DENIED (o_qdeny<=1).
    - Otherwise the timeout decrements.
    - Drain and expiry in the same cycle: accept wins.
  - STOPPED: AW/AR blocked; i_qreq_n=1 -> RUN (o_qaccept_n<=1).
  - DENIED: traffic allowed; i_qreq_n=1 -> RUN (o_qdeny<=0).
- o_qaccept_n=0 and o_qdeny=1 are never asserted together.
- i_qreq_n is sampled synchronously; it is generated in the i_clk domain, so no synchronizer is needed.
- Reset mid-handshake returns the block to RUN with all counters cleared. The controller is reset by the same i_rst_n.

Decomposition:
- Shared package apu_pmu_pkg: qdev_state_e enum (RUN, REQUEST, STOPPED, DENIED) and default width constants.
- Natural sub-module: apu_axi_ostd_counter, a saturating up/down counter with underflow flag, instantiated twice (write and read).

Test Plan:
- Idle, i_deny_timeout=4, QREQn falls -> o_qaccept_n=0 two edges later. QREQn rises -> o_qaccept_n=1 on the next edge.
- 3 ARs outstanding, timeout=10, QREQn falls, 3 R-last within 5 cycles -> ACCEPT within 1 cycle of the last R. No AR forwarded while in REQUEST.
- 1 AW outstanding, no B, timeout=4 -> o_qdeny=1 after 5 cycles. AW traffic flows again. QREQn rises -> o_qdeny=0.
- AW valid stalled (i_m_aw_ready=0) when QREQn falls -> o_m_aw_valid stays 1 until ready. Accept only after the B returns.
- STOPPED, i_s_ar_valid rises -> o_qactive=1 the same cycle, o_s_ar_ready=0 until RUN.
- B handshake with wr_cnt=0 -> o_cnt_err=1 and wr_cnt stays 0. Issuing 63 AWs (width 6) -> o_s_aw_ready=0 until a B arrives.
